// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake bundle for the decode stage.
// The master drives the fetch side and consumes the decoded bundle.
// The slave is the decode stage itself.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_alu_op;
    logic [11:0]     out_ctrl;
    logic            out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_funct3, out_imm, out_alu_op, out_ctrl, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_funct3, out_imm, out_alu_op, out_ctrl, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I + M + Zicsr decode stage with a one-entry skid buffer.
// in_ready is a pure register output; illegal encodings are flagged, not dropped.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    decode_stage_if.slave    bus,
    output logic [CNT_W-1:0] decode_count
);
    localparam bit RV64 = (XLEN == 64);

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_MUL    = 5'd10;
    localparam logic [4:0] ALU_MULH   = 5'd11;
    localparam logic [4:0] ALU_MULHSU = 5'd12;
    localparam logic [4:0] ALU_MULHU  = 5'd13;
    localparam logic [4:0] ALU_DIV    = 5'd14;
    localparam logic [4:0] ALU_DIVU   = 5'd15;
    localparam logic [4:0] ALU_REM    = 5'd16;
    localparam logic [4:0] ALU_REMU   = 5'd17;

    // bit positions inside out_ctrl
    localparam int C_32 = 11, C_CSRSC = 10, C_CSRI = 9, C_CSR = 8, C_STORE = 7, C_LOAD = 6;
    localparam int C_BZERO = 5, C_BRANCH = 4, C_JUMP = 3, C_JALR = 2, C_IMM = 1, C_PC = 0;

    typedef enum logic [2:0] {IT_R, IT_I, IT_S, IT_B, IT_U, IT_J} itype_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        logic [4:0]      alu_op;
        logic [11:0]     ctrl;
        logic            illegal;
    } bundle_t;

    // ALU op of the base integer register/immediate ops, selected by funct3
    function automatic logic [4:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [31:0]        inst;
    logic [6:0]         opcode;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic signed [11:0] imm_i12;
    logic signed [11:0] imm_s12;
    logic signed [12:0] imm_b13;
    logic signed [31:0] imm_u32;
    logic signed [20:0] imm_j21;

    assign inst    = bus.in_inst;
    assign opcode  = inst[6:0];
    assign f3      = inst[14:12];
    assign f7      = inst[31:25];
    assign imm_i12 = inst[31:20];
    assign imm_s12 = {inst[31:25], inst[11:7]};
    assign imm_b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u32 = {inst[31:12], 12'h000};
    assign imm_j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    itype_e     itype;
    logic       legal;
    logic [4:0] alu;
    logic [11:0] ctrl;
    bundle_t    dec;

    // Combinational decode of the word currently offered by fetch
    always_comb begin
        itype = IT_R;
        legal = 1'b0;
        alu   = ALU_ADD;
        ctrl  = '0;
        case (opcode)
            OPC_OP: begin
                legal = 1'b1;
                case (f7)
                    7'b0000000: alu = base_alu(f3);
                    7'b0100000: begin
                        if (f3 == 3'b000)      alu = ALU_SUB;
                        else if (f3 == 3'b101) alu = ALU_SRA;
                        else                   legal = 1'b0;
                    end
                    7'b0000001: alu = ALU_MUL + {2'b00, f3};
                    default:    legal = 1'b0;
                endcase
            end
            OPC_OP_32: begin
                legal       = RV64;
                ctrl[C_32]  = 1'b1;
                case ({f7, f3})
                    {7'b0000000, 3'b000}: alu = ALU_ADD;
                    {7'b0000000, 3'b001}: alu = ALU_SLL;
                    {7'b0000000, 3'b101}: alu = ALU_SRL;
                    {7'b0100000, 3'b000}: alu = ALU_SUB;
                    {7'b0100000, 3'b101}: alu = ALU_SRA;
                    {7'b0000001, 3'b000}: alu = ALU_MUL;
                    {7'b0000001, 3'b100}: alu = ALU_DIV;
                    {7'b0000001, 3'b101}: alu = ALU_DIVU;
                    {7'b0000001, 3'b110}: alu = ALU_REM;
                    {7'b0000001, 3'b111}: alu = ALU_REMU;
                    default:              legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                itype       = IT_I;
                ctrl[C_IMM] = 1'b1;
                alu         = base_alu(f3);
                legal       = 1'b1;
                // bit 25 is shamt[5], only meaningful on RV64
                if (f3 == 3'b001)
                    legal = (inst[31:26] == 6'b000000) && (RV64 || !inst[25]);
                else if (f3 == 3'b101) begin
                    legal = ((inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000))
                            && (RV64 || !inst[25]);
                    alu   = inst[30] ? ALU_SRA : ALU_SRL;
                end
            end
            OPC_OP_IMM_32: begin
                itype       = IT_I;
                ctrl[C_IMM] = 1'b1;
                ctrl[C_32]  = 1'b1;
                case (f3)
                    3'b000: begin alu = ALU_ADD; legal = RV64; end
                    3'b001: begin alu = ALU_SLL; legal = RV64 && (f7 == 7'b0000000); end
                    3'b101: begin
                        alu   = inst[30] ? ALU_SRA : ALU_SRL;
                        legal = RV64 && ((f7 == 7'b0000000) || (f7 == 7'b0100000));
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                itype        = IT_I;
                ctrl[C_LOAD] = 1'b1;
                ctrl[C_IMM]  = 1'b1;
                case (f3)
                    3'b011, 3'b110: legal = RV64;
                    3'b111:         legal = 1'b0;
                    default:        legal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                itype         = IT_S;
                ctrl[C_STORE] = 1'b1;
                ctrl[C_IMM]   = 1'b1;
                legal         = (f3[2] == 1'b0) && ((f3 != 3'b011) || RV64);
            end
            OPC_BRANCH: begin
                // ALU compares; s_branch_zero selects "taken when result is zero"
                itype          = IT_B;
                ctrl[C_BRANCH] = 1'b1;
                ctrl[C_BZERO]  = (f3 == 3'b000) || f3[0] && f3[2];
                legal          = (f3 != 3'b010) && (f3 != 3'b011);
                case (f3[2:1])
                    2'b00:   alu = ALU_SUB;
                    2'b10:   alu = ALU_SLT;
                    default: alu = ALU_SLTU;
                endcase
            end
            OPC_JALR: begin
                itype        = IT_I;
                ctrl[C_JALR] = 1'b1;
                ctrl[C_JUMP] = 1'b1;
                ctrl[C_IMM]  = 1'b1;
                legal        = (f3 == 3'b000);
            end
            OPC_JAL: begin
                itype        = IT_J;
                ctrl[C_JUMP] = 1'b1;
                ctrl[C_PC]   = 1'b1;
                ctrl[C_IMM]  = 1'b1;
                legal        = 1'b1;
            end
            OPC_LUI: begin
                itype       = IT_U;
                ctrl[C_IMM] = 1'b1;
                legal       = 1'b1;
            end
            OPC_AUIPC: begin
                itype       = IT_U;
                ctrl[C_PC]  = 1'b1;
                ctrl[C_IMM] = 1'b1;
                legal       = 1'b1;
            end
            OPC_MISC_MEM: begin
                // FENCE (fm=0000) and FENCE.TSO (fm=1000) only
                itype = IT_I;
                legal = (f3 == 3'b000) && ((inst[31:28] == 4'b0000) || (inst[31:28] == 4'b1000));
            end
            OPC_SYSTEM: begin
                itype = IT_I;
                if (f3 == 3'b000)
                    legal = (inst[31:7] == 25'h0) || (inst[31:7] == 25'h0002000);
                else if (f3 == 3'b100)
                    legal = 1'b0;
                else begin
                    legal         = 1'b1;
                    ctrl[C_CSR]   = 1'b1;
                    ctrl[C_CSRI]  = f3[2];
                    ctrl[C_CSRSC] = f3[1];
                end
            end
            default: legal = 1'b0;
        endcase

        dec         = '0;
        dec.pc      = bus.in_pc;
        dec.funct3  = f3;
        dec.illegal = !legal;
        dec.alu_op  = legal ? alu : ALU_ADD;
        dec.ctrl    = legal ? ctrl : 12'h000;
        dec.rs1     = (itype == IT_U || itype == IT_J) ? 5'd0 : inst[19:15];
        dec.rs2     = (itype == IT_R || itype == IT_S || itype == IT_B) ? inst[24:20] : 5'd0;
        dec.rd      = (!legal || itype == IT_S || itype == IT_B) ? 5'd0 : inst[11:7];
        case (itype)
            IT_I:    dec.imm = XLEN'(imm_i12);
            IT_S:    dec.imm = XLEN'(imm_s12);
            IT_B:    dec.imm = XLEN'(imm_b13);
            IT_U:    dec.imm = XLEN'(imm_u32);
            IT_J:    dec.imm = XLEN'(imm_j21);
            default: dec.imm = '0;
        endcase
    end

    bundle_t out_q;
    bundle_t skid_q;
    logic    out_valid_q;
    logic    skid_valid_q;
    logic    in_ready_q;
    logic    in_xfer;

    assign in_xfer = bus.in_valid && in_ready_q && !flush;

    // Output register, skid entry, registered in_ready and accept counter
    always_ff @(posedge clock) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            decode_count <= '0;
        end else begin
            if (in_xfer)
                decode_count <= decode_count + CNT_W'(1);
            if (flush) begin
                out_valid_q  <= 1'b0;
                skid_valid_q <= 1'b0;
                in_ready_q   <= 1'b1;
            end else if (!out_valid_q || bus.out_ready) begin
                // output slot frees up this cycle; skid entry is older so it goes first
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= 1'b0;
                end else if (in_xfer) begin
                    out_q       <= dec;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
                in_ready_q <= 1'b1;
            end else if (in_xfer) begin
                skid_q       <= dec;
                skid_valid_q <= 1'b1;
                in_ready_q   <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_rs1     = out_q.rs1;
    assign bus.out_rs2     = out_q.rs2;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_funct3  = out_q.funct3;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_alu_op  = out_q.alu_op;
    assign bus.out_ctrl    = out_q.ctrl;
    assign bus.out_illegal = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an RV32 (4-bit counter) and an RV64 instance
// see the same stimulus so XLEN-dependent legality can be compared side by side.
module tb_decode_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic [3:0]  count32;
    logic [31:0] count64;
    int          n_asserts = 0;
    int          n_fail    = 0;

    always #5 clock = ~clock;

    decode_stage_if #(.XLEN(32)) if32();
    decode_stage_if #(.XLEN(64)) if64();

    assign if32.in_valid  = in_valid;
    assign if32.in_inst   = in_inst;
    assign if32.in_pc     = in_pc[31:0];
    assign if32.out_ready = out_ready;
    assign if64.in_valid  = in_valid;
    assign if64.in_inst   = in_inst;
    assign if64.in_pc     = in_pc;
    assign if64.out_ready = out_ready;

    decode_stage #(.XLEN(32), .CNT_W(4)) dut32 (
        .clock(clock), .reset(reset), .flush(flush), .bus(if32), .decode_count(count32)
    );
    decode_stage #(.XLEN(64), .CNT_W(32)) dut64 (
        .clock(clock), .reset(reset), .flush(flush), .bus(if64), .decode_count(count64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [63:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        tick();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = 32'h0; in_pc = 64'h0;
        tick();
        tick();
        chk("rst_out_valid", if32.out_valid, 0);
        chk("rst_in_ready", if32.in_ready, 0);
        chk("rst_count", count32, 0);
        chk("rst_imm", if64.out_imm, 0);
        chk("rst_ctrl", if32.out_ctrl, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", if32.in_ready, 1);

        // T1: addi x1,x0,5
        send(32'h00500093, 64'h100);
        in_valid = 1'b0;
        chk("t1_valid", if32.out_valid, 1);
        chk("t1_rd", if32.out_rd, 1);
        chk("t1_rs1", if32.out_rs1, 0);
        chk("t1_rs2", if32.out_rs2, 0);
        chk("t1_imm", if32.out_imm, 5);
        chk("t1_alu", if32.out_alu_op, 0);
        chk("t1_ctrl", if32.out_ctrl, 12'h002);
        chk("t1_illegal", if32.out_illegal, 0);
        chk("t1_pc", if32.out_pc, 64'h100);
        chk("t1_count", count32, 1);
        tick();
        chk("t1_drain", if32.out_valid, 0);

        // T3/T4 and more, back-to-back with out_ready=1
        send(32'hFFFFFFFF, 64'h110);
        chk("ffff_ill32", if32.out_illegal, 1);
        chk("ffff_ctrl32", if32.out_ctrl, 0);
        chk("ffff_ill64", if64.out_illegal, 1);
        send(32'h0000001B, 64'h114);
        chk("addiw_valid", if32.out_valid, 1);
        chk("addiw_ill32", if32.out_illegal, 1);
        chk("addiw_ctrl32", if32.out_ctrl, 0);
        chk("addiw_ill64", if64.out_illegal, 0);
        chk("addiw_ctrl64", if64.out_ctrl, 12'h802);
        send(32'h02009093, 64'h118);
        chk("slli32_ill32", if32.out_illegal, 1);
        chk("slli32_rd32", if32.out_rd, 0);
        chk("slli32_ill64", if64.out_illegal, 0);
        chk("slli32_alu64", if64.out_alu_op, 2);
        chk("slli32_rd64", if64.out_rd, 1);
        send(32'hFE000EE3, 64'h11C);
        chk("beq_imm32", if32.out_imm, 64'h00000000FFFFFFFC);
        chk("beq_imm64", if64.out_imm, 64'hFFFFFFFFFFFFFFFC);
        chk("beq_ctrl", if32.out_ctrl, 12'h030);
        chk("beq_rd", if32.out_rd, 0);
        chk("beq_illegal", if32.out_illegal, 0);
        send(32'h402081B3, 64'h120);
        chk("sub_alu", if32.out_alu_op, 1);
        chk("sub_rd", if32.out_rd, 3);
        chk("sub_rs1", if32.out_rs1, 1);
        chk("sub_rs2", if32.out_rs2, 2);
        chk("sub_imm", if32.out_imm, 0);
        send(32'h00813283, 64'h124);
        chk("ld_ill32", if32.out_illegal, 1);
        chk("ld_ill64", if64.out_illegal, 0);
        chk("ld_ctrl64", if64.out_ctrl, 12'h042);
        chk("ld_imm64", if64.out_imm, 8);
        chk("ld_funct3", if64.out_funct3, 3);
        send(32'h00000073, 64'h128);
        chk("ecall_ill", if32.out_illegal, 0);
        chk("ecall_ctrl", if32.out_ctrl, 0);
        send(32'h00200073, 64'h12C);
        chk("sys_bad_ill", if32.out_illegal, 1);
        in_valid = 1'b0;
        tick();
        chk("stream_drain", if32.out_valid, 0);
        chk("stream_count", count32, 9);

        // T2: back-pressure and skid
        out_ready = 1'b0;
        send(32'h00100113, 64'h200);
        chk("bp_a_valid", if32.out_valid, 1);
        chk("bp_a_ready", if32.in_ready, 1);
        send(32'h00200193, 64'h204);
        chk("bp_b_ready", if32.in_ready, 0);
        chk("bp_b_count", count32, 11);
        chk("bp_b_hold_pc", if32.out_pc, 64'h200);
        chk("bp_b_hold_imm", if32.out_imm, 1);
        send(32'h00300213, 64'h208);
        chk("bp_c_ready", if32.in_ready, 0);
        chk("bp_c_count", count32, 11);
        chk("bp_c_hold_pc", if32.out_pc, 64'h200);
        out_ready = 1'b1;
        tick();
        chk("bp_rel_pc", if32.out_pc, 64'h204);
        chk("bp_rel_imm", if32.out_imm, 2);
        chk("bp_rel_ready", if32.in_ready, 1);
        chk("bp_rel_count", count32, 11);
        tick();
        chk("bp_c_pc", if32.out_pc, 64'h208);
        chk("bp_c_rd", if32.out_rd, 4);
        chk("bp_c_count2", count32, 12);
        in_valid = 1'b0;
        tick();
        chk("bp_drain", if32.out_valid, 0);

        // T5: flush with output and skid both full
        out_ready = 1'b0;
        send(32'h00100113, 64'h300);
        send(32'h00200193, 64'h304);
        chk("fl_pre_ready", if32.in_ready, 0);
        in_inst = 32'h00300213;
        flush   = 1'b1;
        tick();
        chk("fl_valid", if32.out_valid, 0);
        chk("fl_ready", if32.in_ready, 1);
        chk("fl_count", count32, 14);
        tick();
        chk("fl2_count", count32, 14);
        chk("fl2_valid", if64.out_valid, 0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fl_after_valid", if32.out_valid, 0);

        // T6: reset mid-stream, then counter wrap
        send(32'h00500093, 64'h400);
        chk("rs_count_pre", count32, 15);
        reset = 1'b1;
        tick();
        chk("rs_valid", if32.out_valid, 0);
        chk("rs_count", count64, 0);
        chk("rs_ready", if32.in_ready, 0);
        chk("rs_imm", if32.out_imm, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rs_after_ready", if32.in_ready, 1);
        in_valid = 1'b1;
        in_inst  = 32'h00100113;
        for (int i = 0; i < 17; i++) tick();
        chk("wrap_valid", if32.out_valid, 1);
        in_valid = 1'b0;
        tick();
        chk("wrap_count32", count32, 1);
        chk("wrap_count64", count64, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
